// File: rtl/vi_stats_latch_ctrl_mc.sv
// vi_stats_latch_ctrl_mc: interval-latch clear controller for NUM_CH stats counter banks.
// Optional saturating overrun counter port enabled by macro VI_STATS_LATCH_OVERRUN_CNT_EN.
module vi_stats_latch_ctrl_mc #(
   parameter int unsigned NUM_CH        = 4,
   parameter int unsigned TIMEOUT_WIDTH = 4,
   parameter int unsigned OVR_CNT_WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     invl_latch_pulse,
   input  logic [NUM_CH-1:0]        ch_enable,
   output logic [NUM_CH-1:0]        clr_req,
   input  logic [NUM_CH-1:0]        clr_ack,
   output logic                     busy,
   output logic                     invl_clr_done_pulse,
   output logic                     invl_clr_timeout_level,
   output logic [NUM_CH-1:0]        timeout_ch_mask,
   output logic                     overrun_pulse
`ifdef VI_STATS_LATCH_OVERRUN_CNT_EN
   ,
   output logic [OVR_CNT_WIDTH-1:0] overrun_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_FINISH = 2'd2
   } state_t;

   localparam logic [TIMEOUT_WIDTH-1:0] TMO_ONE = TIMEOUT_WIDTH'(1);
   localparam logic [TIMEOUT_WIDTH-1:0] TMO_MAX = {TIMEOUT_WIDTH{1'b1}};

   if (NUM_CH < 1 || TIMEOUT_WIDTH < 1 || OVR_CNT_WIDTH < 1) begin : g_param_chk
      $error("vi_stats_latch_ctrl_mc: all width parameters must be at least 1");
   end

   state_t                   state_r;
   state_t                   state_nxt_s;
   logic [NUM_CH-1:0]        pending_r;
   logic [NUM_CH-1:0]        pending_nxt_s;
   logic [NUM_CH-1:0]        remain_s;
   logic [TIMEOUT_WIDTH-1:0] tmo_cnt_r;
   logic [TIMEOUT_WIDTH-1:0] tmo_cnt_nxt_s;
   logic                     tmo_level_r;
   logic                     tmo_level_nxt_s;
   logic [NUM_CH-1:0]        tmo_mask_r;
   logic [NUM_CH-1:0]        tmo_mask_nxt_s;
   logic                     busy_r;
   logic                     done_r;
   logic                     overrun_r;
   logic                     drop_s;

   // An ack landing in the same cycle as the last count still counts as an answer.
   assign remain_s = pending_r & ~clr_ack;
   assign drop_s   = invl_latch_pulse & (state_r != ST_IDLE);

   // Next-state, pending-set, timeout counter and sticky status decode.
   always_comb begin
      state_nxt_s     = state_r;
      pending_nxt_s   = pending_r;
      tmo_cnt_nxt_s   = tmo_cnt_r;
      tmo_level_nxt_s = tmo_level_r;
      tmo_mask_nxt_s  = tmo_mask_r;
      case (state_r)
         ST_IDLE: begin
            if (invl_latch_pulse) begin
               tmo_level_nxt_s = 1'b0;
               tmo_mask_nxt_s  = '0;
               if (ch_enable != '0) begin
                  state_nxt_s   = ST_WAIT;
                  pending_nxt_s = ch_enable;
                  tmo_cnt_nxt_s = TMO_MAX;
               end else begin
                  state_nxt_s   = ST_FINISH;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_WAIT: begin
            tmo_cnt_nxt_s = tmo_cnt_r - TMO_ONE;
            pending_nxt_s = remain_s;
            if (remain_s == '0) begin
               state_nxt_s = ST_FINISH;
            end else if (tmo_cnt_r == TMO_ONE) begin
               state_nxt_s     = ST_FINISH;
               tmo_mask_nxt_s  = remain_s;
               tmo_level_nxt_s = 1'b1;
               pending_nxt_s   = '0;
            end else begin
               state_nxt_s = ST_WAIT;
            end
         end
         ST_FINISH: begin
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s   = ST_IDLE;
            pending_nxt_s = '0;
         end
      endcase
   end

   // State, request and status registers; flags are registered from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         pending_r   <= '0;
         tmo_cnt_r   <= '0;
         tmo_level_r <= 1'b0;
         tmo_mask_r  <= '0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         overrun_r   <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         pending_r   <= pending_nxt_s;
         tmo_cnt_r   <= tmo_cnt_nxt_s;
         tmo_level_r <= tmo_level_nxt_s;
         tmo_mask_r  <= tmo_mask_nxt_s;
         busy_r      <= (state_nxt_s != ST_IDLE);
         done_r      <= (state_nxt_s == ST_FINISH);
         overrun_r   <= drop_s;
      end
   end

   assign clr_req                = pending_r;
   assign busy                   = busy_r;
   assign invl_clr_done_pulse    = done_r;
   assign invl_clr_timeout_level = tmo_level_r;
   assign timeout_ch_mask        = tmo_mask_r;
   assign overrun_pulse          = overrun_r;

`ifdef VI_STATS_LATCH_OVERRUN_CNT_EN
   localparam logic [OVR_CNT_WIDTH-1:0] OVR_ONE = OVR_CNT_WIDTH'(1);
   localparam logic [OVR_CNT_WIDTH-1:0] OVR_MAX = {OVR_CNT_WIDTH{1'b1}};

   logic [OVR_CNT_WIDTH-1:0] overrun_cnt_r;

   // Saturating count of latch pulses dropped while busy.
   always_ff @(posedge clk) begin
      if (rst) begin
         overrun_cnt_r <= '0;
      end else if (drop_s && (overrun_cnt_r != OVR_MAX)) begin
         overrun_cnt_r <= overrun_cnt_r + OVR_ONE;
      end else begin
         overrun_cnt_r <= overrun_cnt_r;
      end
   end

   assign overrun_cnt = overrun_cnt_r;
`endif

endmodule

// File: tb/tb_vi_stats_latch_ctrl_mc.sv
// Scoreboard bench for vi_stats_latch_ctrl_mc: per-cycle expected output words are queued
// as stimulus is driven (on the falling edge) and popped/compared one cycle later.
module tb_vi_stats_latch_ctrl_mc;

   logic       clk = 1'b0;
   logic       rst;
   logic       invl_latch_pulse;
   logic [3:0] ch_enable;
   logic [3:0] clr_req;
   logic [3:0] clr_ack;
   logic       busy;
   logic       invl_clr_done_pulse;
   logic       invl_clr_timeout_level;
   logic [3:0] timeout_ch_mask;
   logic       overrun_pulse;
`ifdef VI_STATS_LATCH_OVERRUN_CNT_EN
   logic [7:0] overrun_cnt;
`endif

   int checks = 0;
   int errors = 0;
   logic [11:0] sb_q[$];

   always #5 clk = ~clk;

   vi_stats_latch_ctrl_mc #(
      .NUM_CH(4), .TIMEOUT_WIDTH(4), .OVR_CNT_WIDTH(8)
   ) dut (
      .clk                    (clk),
      .rst                    (rst),
      .invl_latch_pulse       (invl_latch_pulse),
      .ch_enable              (ch_enable),
      .clr_req                (clr_req),
      .clr_ack                (clr_ack),
      .busy                   (busy),
      .invl_clr_done_pulse    (invl_clr_done_pulse),
      .invl_clr_timeout_level (invl_clr_timeout_level),
      .timeout_ch_mask        (timeout_ch_mask),
      .overrun_pulse          (overrun_pulse)
`ifdef VI_STATS_LATCH_OVERRUN_CNT_EN
      ,
      .overrun_cnt            (overrun_cnt)
`endif
   );

   // Word layout: {clr_req[3:0], busy, done, level, mask[3:0], overrun}
   function automatic logic [11:0] ew(logic [3:0] req, logic bsy, logic dn, logic lv,
                                      logic [3:0] mk, logic ov);
      return {req, bsy, dn, lv, mk, ov};
   endfunction

   function automatic logic [11:0] obs();
      return {clr_req, busy, invl_clr_done_pulse, invl_clr_timeout_level,
              timeout_ch_mask, overrun_pulse};
   endfunction

   function automatic logic [3:0] req_exp(int n, int last[4]);
      logic [3:0] r;
      for (int i = 0; i < 4; i++) r[i] = (n >= 1) && (n <= last[i]);
      return r;
   endfunction

   task automatic drive(input logic r, input logic lp, input logic [3:0] en, input logic [3:0] ack);
      rst              = r;
      invl_latch_pulse = lp;
      ch_enable        = en;
      clr_ack          = ack;
   endtask

   task automatic test_reset();
      logic [11:0] e, o;
      for (int c = 0; c <= 3; c++) begin
         drive(c < 2, c < 2, 4'hF, 4'h0);
         sb_q.push_back(ew(4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0));
         @(negedge clk);
         e = sb_q.pop_front(); o = obs(); checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL reset n=%0d got=%b expected=%b", c + 1, o, e);
         end
      end
   endtask

   task automatic test_all_ack();
      logic [11:0] e, o;
      int last[4] = '{2, 3, 4, 5};
      for (int c = 0; c <= 8; c++) begin
         int n = c + 1;
         drive(1'b0, c == 0, (c == 0) ? 4'hF : 4'h3,
               (c >= 2 && c <= 5) ? 4'(1 << (c - 2)) : 4'h0);
         sb_q.push_back(ew(req_exp(n, last), n <= 6, n == 6, 1'b0, 4'h0, 1'b0));
         @(negedge clk);
         e = sb_q.pop_front(); o = obs(); checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL all_ack n=%0d got=%b expected=%b", n, o, e);
         end
      end
   endtask

   task automatic test_timeout();
      logic [11:0] e, o;
      int last[4] = '{2, 3, 15, 4};
      logic [3:0] ack;
      for (int c = 0; c <= 19; c++) begin
         int n = c + 1;
         ack = (c == 2) ? 4'b0001 : (c == 3) ? 4'b0010 : (c == 4) ? 4'b1000 : 4'b0000;
         drive(1'b0, c == 0, 4'hF, ack);
         sb_q.push_back(ew(req_exp(n, last), n <= 16, n == 16, n >= 16,
                           (n >= 16) ? 4'b0100 : 4'b0000, 1'b0));
         @(negedge clk);
         e = sb_q.pop_front(); o = obs(); checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL timeout n=%0d got=%b expected=%b", n, o, e);
         end
      end
   endtask

   task automatic test_timeout_clear();
      logic [11:0] e, o;
      int last[4] = '{1, 0, 0, 0};
      for (int c = 0; c <= 3; c++) begin
         int n = c + 1;
         drive(1'b0, c == 0, 4'h1, (c == 1) ? 4'h1 : 4'h0);
         sb_q.push_back(ew(req_exp(n, last), n <= 2, n == 2, 1'b0, 4'h0, 1'b0));
         @(negedge clk);
         e = sb_q.pop_front(); o = obs(); checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL timeout_clear n=%0d got=%b expected=%b", n, o, e);
         end
      end
   endtask

   task automatic test_no_enable();
      logic [11:0] e, o;
      for (int c = 0; c <= 3; c++) begin
         int n = c + 1;
         drive(1'b0, c == 0, 4'h0, 4'h0);
         sb_q.push_back(ew(4'h0, n == 1, n == 1, 1'b0, 4'h0, 1'b0));
         @(negedge clk);
         e = sb_q.pop_front(); o = obs(); checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL no_enable n=%0d got=%b expected=%b", n, o, e);
         end
      end
   endtask

   task automatic test_overrun();
      logic [11:0] e, o;
      int last[4] = '{2, 3, 4, 5};
      for (int c = 0; c <= 9; c++) begin
         int n = c + 1;
         drive(1'b0, (c == 0) || (c == 3) || (c == 6), (c == 3) ? 4'h2 : 4'hF,
               (c >= 2 && c <= 5) ? 4'(1 << (c - 2)) : 4'h0);
         sb_q.push_back(ew(req_exp(n, last), n <= 6, n == 6, 1'b0, 4'h0,
                           (n == 4) || (n == 7)));
         @(negedge clk);
         e = sb_q.pop_front(); o = obs(); checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL overrun n=%0d got=%b expected=%b", n, o, e);
         end
      end
`ifdef VI_STATS_LATCH_OVERRUN_CNT_EN
      checks++;
      if (overrun_cnt !== 8'd2) begin
         errors++;
         $display("FAIL overrun_cnt got=%0d expected=2", overrun_cnt);
      end
      for (int c = 0; c < 400; c++) begin
         drive(1'b0, 1'b1, 4'hF, 4'h0);
         @(negedge clk);
      end
      for (int c = 0; c < 20; c++) begin
         drive(1'b0, 1'b0, 4'h0, 4'h0);
         @(negedge clk);
      end
      checks++;
      if (overrun_cnt !== 8'hFF) begin
         errors++;
         $display("FAIL overrun_cnt_sat got=%0d expected=255", overrun_cnt);
      end
`endif
   endtask

   task automatic test_ack_at_expiry();
      logic [11:0] e, o;
      int last[4] = '{2, 0, 15, 0};
      logic [3:0] ack;
      for (int c = 0; c <= 18; c++) begin
         int n = c + 1;
         ack = (c == 2) ? 4'b0001 : (c == 5) ? 4'b0010 : (c == 7) ? 4'b0001 :
               (c == 15) ? 4'b0100 : 4'b0000;
         drive(1'b0, c == 0, 4'h5, ack);
         sb_q.push_back(ew(req_exp(n, last), n <= 16, n == 16, 1'b0, 4'h0, 1'b0));
         @(negedge clk);
         e = sb_q.pop_front(); o = obs(); checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL ack_at_expiry n=%0d got=%b expected=%b", n, o, e);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [11:0] e, o;
      int last[4] = '{3, 3, 3, 3};
      logic [3:0] ack;
      for (int c = 0; c <= 20; c++) begin
         int n = c + 1;
         ack = (c == 5) ? 4'hF : (c == 6) ? 4'h4 : 4'h0;
         drive(c == 3, c == 0, 4'hF, ack);
         sb_q.push_back(ew(req_exp(n, last), n <= 3, 1'b0, 1'b0, 4'h0, 1'b0));
         @(negedge clk);
         e = sb_q.pop_front(); o = obs(); checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL reset_mid n=%0d got=%b expected=%b", n, o, e);
         end
      end
   endtask

   initial begin
      drive(1'b1, 1'b0, 4'h0, 4'h0);
      @(negedge clk);
      test_reset();
      test_all_ack();
      test_timeout();
      test_timeout_clear();
      test_no_enable();
      test_overrun();
      test_ack_at_expiry();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
